// File: rtl/cskip_serial_adder_pkg.sv
// Shared definitions for the block-serial carry-skip adder:
// FSM state encoding and a small helper used by the overflow logic.
package cskip_serial_adder_pkg;

  // Controller states; encoding kept fixed so waveforms read the same across cskip blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry into the top bit of a slice, recovered from that bit's operands and sum.
  function automatic logic msb_carry_in(input logic a_msb, input logic b_msb, input logic sum_msb);
    return a_msb ^ b_msb ^ sum_msb;
  endfunction

endpackage

// File: rtl/cskip_serial_adder_block.sv
// cskip_block: one combinational carry-skip slice.
// The sum is always the ripple sum; the carry-out bypasses the ripple chain
// when every bit of the slice propagates.
module cskip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             p_all
);

  logic ripple_cout;

  // Ripple adder across the slice, LSB first.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    ripple_cout = carry;
  end

  // Skip mux: a fully propagating slice passes its carry-in straight through.
  always_comb begin
    p_all = &(a ^ b);
    cout  = p_all ? cin : ripple_cout;
  end

endmodule

// File: rtl/cskip_serial_adder.sv
// cskip_serial_adder: WIDTH-bit adder that pushes one BLOCK-bit slice per
// cycle through a single carry-skip slice, LSB first, with the slice carry
// registered between cycles. valid/ready handshake on input and output.
module cskip_serial_adder
  import cskip_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [WIDTH-1:0]                 i_add_term1,
  input  logic [WIDTH-1:0]                 i_add_term2,
  input  logic                             cin,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [WIDTH-1:0]                 o_result,
  output logic                             cout,
  output logic                             o_ovf,
  output logic [$clog2(WIDTH/BLOCK+1)-1:0] o_skip_cnt
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CW   = $clog2(NBLK + 1);

  // Reject geometries the slice sequencing cannot handle.
  generate
    if ((WIDTH % BLOCK) != 0) begin : g_bad_width
      $error("cskip_serial_adder: WIDTH must be a multiple of BLOCK");
    end
    if (NBLK < 2) begin : g_bad_nblk
      $error("cskip_serial_adder: WIDTH/BLOCK must be at least 2");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;        // operand A, shifted right one slice per RUN cycle
  logic [WIDTH-1:0]  b_q, b_d;        // operand B, shifted alongside A
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     skip_q, skip_d;

  logic [BLOCK-1:0]  a_slice, b_slice, sum_slice;
  logic              slice_cout, slice_p;
  logic              last_slice;
  logic              accept;

  // The current slice is always the low BLOCK bits of the shifting operand registers.
  assign a_slice    = a_q[BLOCK-1:0];
  assign b_slice    = b_q[BLOCK-1:0];
  assign last_slice = (idx_q == IDXW'(NBLK - 1));
  assign accept     = o_ready & i_valid;

  cskip_block #(
    .BLOCK (BLOCK)
  ) u_block (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry_q),
    .sum   (sum_slice),
    .cout  (slice_cout),
    .p_all (slice_p)
  );

  // State and datapath registers; reset aborts any add in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      skip_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      skip_q   <= skip_d;
    end
  end

  // Next-state: IDLE -> RUN on accept, RUN -> DONE after the last slice,
  // DONE -> RUN (back-to-back) or IDLE once the consumer takes the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_valid) state_d = RUN;
      RUN:  if (last_slice) state_d = DONE;
      DONE: if (i_ready) state_d = i_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then fold in one slice per RUN cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    skip_d   = skip_q;
    if (accept) begin
      a_d      = i_add_term1;
      b_d      = i_add_term2;
      carry_d  = cin;
      idx_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      skip_d   = '0;
    end else if (state_q == RUN) begin
      result_d[int'(idx_q) * BLOCK +: BLOCK] = sum_slice;
      carry_d = slice_cout;
      a_d     = a_q >> BLOCK;
      b_d     = b_q >> BLOCK;
      if (slice_p) skip_d = skip_q + CW'(1);
      if (last_slice) begin
        cout_d = slice_cout;
        ovf_d  = msb_carry_in(a_slice[BLOCK-1], b_slice[BLOCK-1], sum_slice[BLOCK-1]) ^ slice_cout;
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
  end

  // Outputs: handshake decoded from state, results straight from registers.
  always_comb begin
    o_ready    = (state_q == IDLE) | ((state_q == DONE) & i_ready);
    o_valid    = (state_q == DONE);
    o_result   = result_q;
    cout       = cout_q;
    o_ovf      = ovf_q;
    o_skip_cnt = skip_q;
  end

endmodule

// File: tb/tb_cskip_serial_adder.sv
// Self-checking bench for cskip_serial_adder (WIDTH=16, BLOCK=4):
// directed cases plus random adds against an arithmetic reference model.
module tb_cskip_serial_adder;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_add_term1;
  logic [15:0] i_add_term2;
  logic        cin;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_result;
  logic        cout;
  logic        o_ovf;
  logic [2:0]  o_skip_cnt;

  int total = 0;
  int bad   = 0;

  cskip_serial_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_add_term1 (i_add_term1),
    .i_add_term2 (i_add_term2),
    .cin         (cin),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .cout        (cout),
    .o_ovf       (o_ovf),
    .o_skip_cnt  (o_skip_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer addition, overflow from operand/result signs,
  // skip count as the number of nibbles where A and B differ in every bit.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [15:0] sum, output logic co, output logic ovf,
                       output logic [2:0] skip);
    logic [16:0] full;
    logic [15:0] diff;
    full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    sum  = full[15:0];
    co   = full[16];
    ovf  = (a[15] == b[15]) && (sum[15] != a[15]);
    diff = a ^ b;
    skip = 3'd0;
    for (int k = 0; k < 4; k++)
      if (((diff >> (4 * k)) & 16'h000F) == 16'h000F) skip = skip + 3'd1;
  endtask

  // Present operands at a negedge while the DUT is ready; hold through the accept edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge i_clk);
    check("ready_before_accept", o_ready, 1'b1);
    i_add_term1 = a;
    i_add_term2 = b;
    cin         = c;
    i_valid     = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid     = 1'b0;
    i_add_term1 = 16'($urandom);
    i_add_term2 = 16'($urandom);
    cin         = 1'($urandom);
  endtask

  // Called #1 after the accept edge: count edges to o_valid, then compare results.
  task automatic wait_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic c);
    logic [15:0] es;
    logic        ec, eo;
    logic [2:0]  ek;
    int          cycles;
    model(a, b, c, es, ec, eo, ek);
    cycles = 0;
    while (!o_valid && cycles < 20) begin
      @(posedge i_clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        check({tag, "_busy_ready"}, o_ready, 1'b0);
      end
    end
    check({tag, "_latency"}, cycles, 4);
    check({tag, "_result"}, o_result, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, o_ovf, eo);
    check({tag, "_skip"}, o_skip_cnt, ek);
    $display("add %s: A=%h B=%h cin=%0d -> sum=%h cout=%0d ovf=%0d skip=%0d (%0d cycles)",
             tag, a, b, c, o_result, cout, o_ovf, o_skip_cnt, cycles);
  endtask

  // With i_ready high the result is consumed on the next edge.
  task automatic drain(input string tag);
    @(posedge i_clk);
    #1;
    check({tag, "_valid_drop"}, o_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] ra, rb, held;
    logic        rc;

    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    i_add_term1 = 16'h0;
    i_add_term2 = 16'h0;
    cin         = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_result", o_result, 16'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", o_ovf, 1'b0);
    check("rst_skip", o_skip_cnt, 3'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // 1: full carry ripple with three skipping slices
    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_and_check("t1", 16'hFFFF, 16'h0001, 1'b0);
    check("t1_literal_result", o_result, 16'h0000);
    check("t1_literal_skip", o_skip_cnt, 3'd3);
    drain("t1");

    // 2: carry-in used
    accept(16'h1234, 16'h4321, 1'b1);
    wait_and_check("t2", 16'h1234, 16'h4321, 1'b1);
    check("t2_literal_result", o_result, 16'h5556);
    drain("t2");

    // 3: signed overflow both directions
    accept(16'h7FFF, 16'h0001, 1'b0);
    wait_and_check("t3a", 16'h7FFF, 16'h0001, 1'b0);
    drain("t3a");
    accept(16'h8000, 16'h8000, 1'b0);
    wait_and_check("t3b", 16'h8000, 16'h8000, 1'b0);
    drain("t3b");

    // 4: backpressure, result held while stray i_valid pulses are ignored
    i_ready = 1'b0;
    accept(16'h00FF, 16'h0F0F, 1'b0);
    wait_and_check("t4", 16'h00FF, 16'h0F0F, 1'b0);
    held = o_result;
    check("t4_literal_result", held, 16'h100E);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_valid     = 1'($urandom);
      i_add_term1 = 16'($urandom);
      i_add_term2 = 16'($urandom);
      #1;
      check("t4_hold_ready", o_ready, 1'b0);
      @(posedge i_clk);
      #1;
      check("t4_hold_valid", o_valid, 1'b1);
      check("t4_hold_result", o_result, held);
      check("t4_hold_skip", o_skip_cnt, 3'd2);
      $display("hold cycle %0d: valid=%0d result=%h", i, o_valid, o_result);
    end

    // 5: back-to-back accept in DONE
    @(negedge i_clk);
    i_ready     = 1'b1;
    i_valid     = 1'b1;
    i_add_term1 = 16'h0001;
    i_add_term2 = 16'h0002;
    cin         = 1'b0;
    #1;
    check("t5_ready_in_done", o_ready, 1'b1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_add_term1 = 16'hDEAD;
    check("t5_first_consumed", o_valid, 1'b0);
    wait_and_check("t5", 16'h0001, 16'h0002, 1'b0);
    check("t5_literal_result", o_result, 16'h0003);
    drain("t5");

    // 6: asynchronous reset in the middle of RUN
    accept(16'h1111, 16'h2222, 1'b0);
    @(posedge i_clk);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_result", o_result, 16'h0);
    check("t6_rst_valid", o_valid, 1'b0);
    check("t6_rst_cout", cout, 1'b0);
    check("t6_rst_skip", o_skip_cnt, 3'd0);
    check("t6_rst_ready", o_ready, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      check("t6_no_stale_valid", o_valid, 1'b0);
    end
    accept(16'h0010, 16'h0010, 1'b0);
    wait_and_check("t6", 16'h0010, 16'h0010, 1'b0);
    check("t6_literal_result", o_result, 16'h0020);
    drain("t6");

    // Random adds, with the occasional operand pattern forcing skips
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = (n % 4 == 0) ? ~ra : 16'($urandom);
      rc = 1'($urandom);
      accept(ra, rb, rc);
      wait_and_check("rand", ra, rb, rc);
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
